// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase scheduler: phase encoding, way index and lamp helpers.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_ALLRED = 2'd3
    } phase_e;

    typedef logic [1:0] way_t;

    localparam logic [3:0] ALL_RED_LAMPS = 4'b1111;

    function automatic logic [3:0] way_onehot(input way_t w);
        way_onehot = 4'b0001 << w;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick over four ways; the search starts one above base.
module rr_arbiter4
    import traffic_pkg::*;
(
    input  logic [3:0] pending,
    input  way_t       base,
    output way_t       winner,
    output logic       valid
);

    logic [3:0] rot_s;
    way_t       off_s;

    // Rotate the request mask so bit 0 is the way just above base, then priority-encode.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rot_s[k] = pending[way_t'(base + way_t'(k) + 2'd1)];
        end
        if (rot_s[0]) begin
            off_s = 2'd0;
        end else if (rot_s[1]) begin
            off_s = 2'd1;
        end else if (rot_s[2]) begin
            off_s = 2'd2;
        end else if (rot_s[3]) begin
            off_s = 2'd3;
        end else begin
            off_s = 2'd0;
        end
        valid  = |rot_s;
        winner = way_t'(base + off_s + 2'd1);
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-way phase scheduler with min/max green, yellow and all-red timing
// plus an emergency preempt that overrides the round-robin order.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_WAY     = 4,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_WAY-1:0] req,
    input  logic             preempt,
    input  logic [1:0]       preempt_way,
    output logic [N_WAY-1:0] g,
    output logic [N_WAY-1:0] y,
    output logic [N_WAY-1:0] r,
    output logic [1:0]       active_way,
    output logic             grant
);

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    phase_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [3:0]       pending_r;
    logic [3:0]       others_s;
    way_t             rr_base_r;
    way_t             arb_way_s;
    logic             arb_valid_s;
    way_t             pick_way_s;
    logic             pick_valid_s;
    logic             green_exit_s;
    logic             enter_green_s;

    rr_arbiter4 u_arb (
        .pending (pending_r),
        .base    (rr_base_r),
        .winner  (arb_way_s),
        .valid   (arb_valid_s)
    );

    // Winner selection, green exit test and the decision to start a new green.
    always_comb begin
        cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
        others_s  = pending_r & ~way_onehot(active_way);

        if (preempt) begin
            pick_way_s   = preempt_way;
            pick_valid_s = 1'b1;
        end else begin
            pick_way_s   = arb_way_s;
            pick_valid_s = arb_valid_s;
        end

        // A preempt to another way cuts green short regardless of MIN_GREEN.
        if (preempt) begin
            green_exit_s = (preempt_way != active_way);
        end else begin
            green_exit_s = (others_s != 4'b0000) && (cnt_r >= MIN_LAST) &&
                           (!req[active_way] || (cnt_r >= MAX_LAST));
        end

        case (state_r)
            PH_IDLE:   enter_green_s = pick_valid_s;
            PH_ALLRED: enter_green_s = pick_valid_s && (cnt_r == AR_LAST);
            default:   enter_green_s = 1'b0;
        endcase
    end

    // Phase sequencer with registered lamps, grant pulse and pending latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= PH_IDLE;
            cnt_r      <= '0;
            pending_r  <= 4'b0000;
            rr_base_r  <= 2'd3;
            active_way <= 2'd0;
            g          <= 4'b0000;
            y          <= 4'b0000;
            r          <= ALL_RED_LAMPS;
            grant      <= 1'b0;
        end else begin
            grant     <= 1'b0;
            pending_r <= (pending_r | req) &
                         ~(enter_green_s ? way_onehot(pick_way_s) : 4'b0000);
            if (enter_green_s) begin
                state_r    <= PH_GREEN;
                cnt_r      <= '0;
                active_way <= pick_way_s;
                rr_base_r  <= pick_way_s;
                grant      <= 1'b1;
                g          <= way_onehot(pick_way_s);
                y          <= 4'b0000;
                r          <= ~way_onehot(pick_way_s);
            end else begin
                case (state_r)
                    PH_GREEN: begin
                        if (green_exit_s) begin
                            state_r <= PH_YELLOW;
                            cnt_r   <= '0;
                            g       <= 4'b0000;
                            y       <= way_onehot(active_way);
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    PH_YELLOW: begin
                        if (cnt_r == YEL_LAST) begin
                            state_r <= PH_ALLRED;
                            cnt_r   <= '0;
                            y       <= 4'b0000;
                            r       <= ALL_RED_LAMPS;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    PH_ALLRED: begin
                        if (cnt_r == AR_LAST) begin
                            state_r <= PH_IDLE;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    default: begin
                        cnt_r <= cnt_inc_s;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus randomized traffic against a phase model.
module tb_traffic_phase_scheduler;

    localparam int MIN_GREEN = 5;
    localparam int MAX_GREEN = 15;
    localparam int YELLOW    = 3;
    localparam int ALL_RED   = 1;
    localparam int CNT_W     = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       preempt = 1'b0;
    logic [1:0] preempt_way = 2'd0;
    logic [3:0] g, y, r;
    logic [1:0] active_way;
    logic       grant;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 idle, 1 green, 2 yellow, 3 all-red; age = cycles spent in phase.
    int       m_phase, m_age, m_way, m_start;
    bit [3:0] m_pend;
    bit       m_grant;

    traffic_phase_scheduler #(
        .N_WAY(4), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .YELLOW(YELLOW), .ALL_RED(ALL_RED), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .preempt(preempt), .preempt_way(preempt_way),
        .g(g), .y(y), .r(r), .active_way(active_way), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int       win;
        int       nphase;
        bit [3:0] np;
        bit       others;
        if (rst) begin
            m_phase = 0; m_age = 0; m_way = 0; m_start = 0; m_pend = 4'b0000; m_grant = 1'b0;
            return;
        end
        win = -1;
        if (preempt) win = int'(preempt_way);
        else for (int k = 0; k < 4; k++)
            if (win < 0 && m_pend[(m_start + k) % 4]) win = (m_start + k) % 4;
        np = m_pend | req;
        nphase = m_phase;
        m_grant = 1'b0;
        case (m_phase)
            0: if (win >= 0) nphase = 1;
            1: begin
                others = (m_pend & ~(4'b0001 << m_way)) != 4'b0000;
                if (preempt ? (int'(preempt_way) != m_way)
                            : (others && m_age >= MIN_GREEN - 1 &&
                               (!req[m_way] || m_age >= MAX_GREEN - 1)))
                    nphase = 2;
            end
            2: if (m_age == YELLOW - 1) nphase = 3;
            default: if (m_age == ALL_RED - 1) nphase = (win >= 0) ? 1 : 0;
        endcase
        if (nphase == 1 && m_phase != 1) begin
            np[win] = 1'b0; m_way = win; m_start = (win + 1) % 4; m_grant = 1'b1;
        end
        m_age = (nphase != m_phase) ? 0 : ((m_age < 31) ? m_age + 1 : 31);
        m_phase = nphase;
        m_pend = np;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; preempt = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (g !== 4'b0000) begin n_bad++; $display("FAIL reset_g: got %b want 0000", g); end
            n_cmp++; if (y !== 4'b0000) begin n_bad++; $display("FAIL reset_y: got %b want 0000", y); end
            n_cmp++; if (r !== 4'b1111) begin n_bad++; $display("FAIL reset_r: got %b want 1111", r); end
            n_cmp++; if (active_way !== 2'd0) begin n_bad++; $display("FAIL reset_way: got %0d want 0", active_way); end
            n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL reset_grant: got %b want 0", grant); end
            tick();
        end
    endtask

    task automatic test_single_req();
        int grants = 0;
        int bad_hold = 0;
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        n_cmp++; if (g !== 4'b0000) begin n_bad++; $display("FAIL single_latency: got g=%b want 0000", g); end
        tick();
        n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL single_green: got g=%b want 0001", g); end
        n_cmp++; if (grant !== 1'b1) begin n_bad++; $display("FAIL single_grant: got %b want 1", grant); end
        for (int i = 0; i < 32; i++) begin
            tick();
            if (grant) grants++;
            if (g !== 4'b0001 || y !== 4'b0000) bad_hold++;
        end
        n_cmp++; if (grants != 0) begin n_bad++; $display("FAIL single_extra_grant: got %0d want 0", grants); end
        n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL single_hold: got %0d off cycles want 0", bad_hold); end
    endtask

    task automatic test_min_green();
        logic [3:0] eg, ey;
        do_reset();
        req = 4'b0101;
        tick();
        req = 4'b0000;
        tick();
        n_cmp++; if (g !== 4'b0001 || grant !== 1'b1) begin n_bad++; $display("FAIL min_start: got g=%b grant=%b want 0001/1", g, grant); end
        for (int t = 1; t <= 9; t++) begin
            tick();
            eg = (t <= 4) ? 4'b0001 : ((t == 9) ? 4'b0100 : 4'b0000);
            ey = (t >= 5 && t <= 7) ? 4'b0001 : 4'b0000;
            n_cmp++; if (g !== eg) begin n_bad++; $display("FAIL min_g t=%0d: got %b want %b", t, g, eg); end
            n_cmp++; if (y !== ey) begin n_bad++; $display("FAIL min_y t=%0d: got %b want %b", t, y, ey); end
        end
    endtask

    task automatic test_max_green();
        logic [3:0] eg, ey;
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL max_start: got g=%b want 0001", g); end
        for (int t = 1; t <= 19; t++) begin
            req = (t == 1) ? 4'b0011 : 4'b0001;
            tick();
            eg = (t <= 14) ? 4'b0001 : ((t == 19) ? 4'b0010 : 4'b0000);
            ey = (t >= 15 && t <= 17) ? 4'b0001 : 4'b0000;
            n_cmp++; if (g !== eg) begin n_bad++; $display("FAIL max_g t=%0d: got %b want %b", t, g, eg); end
            n_cmp++; if (y !== ey) begin n_bad++; $display("FAIL max_y t=%0d: got %b want %b", t, y, ey); end
        end
        req = 4'b0000;
    endtask

    task automatic test_order();
        int ways[$];
        int times[$];
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        req = 4'b1011;
        tick();
        req = 4'b0000;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (grant) begin ways.push_back(int'(active_way)); times.push_back(t); end
        end
        n_cmp++;
        if (ways.size() != 3) begin
            n_bad++; $display("FAIL order_count: got %0d grants want 3", ways.size());
        end else begin
            n_cmp++; if (ways[0] != 1) begin n_bad++; $display("FAIL order_first: got %0d want 1", ways[0]); end
            n_cmp++; if (ways[1] != 3) begin n_bad++; $display("FAIL order_second: got %0d want 3", ways[1]); end
            n_cmp++; if (ways[2] != 0) begin n_bad++; $display("FAIL order_third: got %0d want 0", ways[2]); end
            n_cmp++; if (times[1] - times[0] != 9) begin n_bad++; $display("FAIL order_gap1: got %0d want 9", times[1] - times[0]); end
            n_cmp++; if (times[2] - times[1] != 9) begin n_bad++; $display("FAIL order_gap2: got %0d want 9", times[2] - times[1]); end
        end
    endtask

    task automatic test_preempt();
        int bad_hold = 0;
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0101;
        tick();
        tick();
        req = 4'b0000; preempt = 1'b1; preempt_way = 2'd3;
        tick();
        n_cmp++; if (y !== 4'b0010 || g !== 4'b0000) begin n_bad++; $display("FAIL pre_yellow: got g=%b y=%b want 0000/0010", g, y); end
        tick();
        tick();
        tick();
        n_cmp++; if (r !== 4'b1111) begin n_bad++; $display("FAIL pre_allred: got r=%b want 1111", r); end
        tick();
        n_cmp++; if (g !== 4'b1000 || grant !== 1'b1) begin n_bad++; $display("FAIL pre_green: got g=%b grant=%b want 1000/1", g, grant); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (g !== 4'b1000) bad_hold++;
        end
        n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL pre_hold: got %0d off cycles want 0", bad_hold); end
        preempt = 1'b0;
        tick();
        n_cmp++; if (y !== 4'b1000) begin n_bad++; $display("FAIL pre_release: got y=%b want 1000", y); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (y !== 4'b0010) begin n_bad++; $display("FAIL mid_in_yellow: got y=%b want 0010", y); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (r !== 4'b1111 || g !== 4'b0000 || y !== 4'b0000) begin n_bad++; $display("FAIL mid_lamps: got r=%b g=%b y=%b want 1111/0000/0000", r, g, y); end
        n_cmp++; if (active_way !== 2'd0 || grant !== 1'b0) begin n_bad++; $display("FAIL mid_way: got way=%0d grant=%b want 0/0", active_way, grant); end
        req = 4'b0100;
        tick();
        req = 4'b0000;
        n_cmp++; if (g !== 4'b0000) begin n_bad++; $display("FAIL mid_stale: got g=%b want 0000", g); end
        tick();
        n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL mid_new: got g=%b want 0100", g); end
    endtask

    task automatic test_random();
        logic [3:0] hold = 4'b0000;
        logic [3:0] eg, ey;
        int pre_left = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 25 == 0) hold = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            req = hold | (($urandom_range(0, 7) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000);
            if (pre_left > 0) pre_left--;
            else if ($urandom_range(0, 59) == 0) begin
                pre_left = $urandom_range(1, 30);
                preempt_way = 2'($urandom_range(0, 3));
            end
            preempt = (pre_left > 0);
            rst = ($urandom_range(0, 699) == 0);
            tick();
            eg = (m_phase == 1) ? (4'b0001 << m_way) : 4'b0000;
            ey = (m_phase == 2) ? (4'b0001 << m_way) : 4'b0000;
            n_cmp++; if (g !== eg) begin n_bad++; if (n_bad <= 30) $display("FAIL rand_g c=%0d: got %b want %b", c, g, eg); end
            n_cmp++; if (y !== ey) begin n_bad++; if (n_bad <= 30) $display("FAIL rand_y c=%0d: got %b want %b", c, y, ey); end
            n_cmp++; if (r !== ~(eg | ey)) begin n_bad++; if (n_bad <= 30) $display("FAIL rand_r c=%0d: got %b want %b", c, r, ~(eg | ey)); end
            n_cmp++; if (active_way !== 2'(m_way)) begin n_bad++; if (n_bad <= 30) $display("FAIL rand_way c=%0d: got %0d want %0d", c, active_way, m_way); end
            n_cmp++; if (grant !== m_grant) begin n_bad++; if (n_bad <= 30) $display("FAIL rand_grant c=%0d: got %b want %b", c, grant, m_grant); end
        end
        rst = 1'b0; req = 4'b0000; preempt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_min_green();
        test_max_green();
        test_order();
        test_preempt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-actuated phase scheduler for a 4-approach intersection.
- Each approach raises a vehicle-sensor request. The block grants green to one approach at a time, in round-robin order, with min/max green, yellow and all-red clearance timing.
- An emergency preempt input overrides the round-robin order.
- Sits above the per-lamp drivers and produces the registered r/y/g lamp vectors directly.

Parameters:
- N_WAY, 4, number of approaches (fixed at 4 in this revision; ports sized accordingly)
- MIN_GREEN, 5, minimum green cycles (>=1)
- MAX_GREEN, 15, maximum green cycles while others wait (>=MIN_GREEN)
- YELLOW, 3, yellow cycles (>=1)
- ALL_RED, 1, all-red clearance cycles (>=1)
- CNT_W, 5, phase counter width; must hold MAX_GREEN-1

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req  input  4  per-approach vehicle sensor, level
- preempt  input  1  emergency preempt request, level
- preempt_way  input  2  approach to preempt to; valid while preempt=1
- g  output  4  green lamps, one-hot or zero
- y  output  4  yellow lamps, one-hot or zero
- r  output  4  red lamps
- active_way  output  2  approach currently green/yellow (last served when all red)
- grant  output  1  one-cycle pulse on the first cycle of each GREEN

Behaviour:
- **Single clock, synchronous active-high reset.** All state and outputs are registered.
- **Reset values:** state=IDLE, r=4'b1111, g=0, y=0, active_way=0, grant=0, pending=0, cnt=0, rr pointer so the first search starts at way 0.
- **Pending latch:**
  - pending[i] is set on any cycle with req[i]=1.
  - pending[i] is cleared on the cycle way i enters GREEN. Clear beats set for that way on the same cycle.
- **States:** IDLE, GREEN, YELLOW, ALLRED. cnt resets to 0 on every state change, otherwise increments and saturates at 2^CNT_W-1.
- **IDLE** (all red): if pending!=0 or preempt, pick a winner; next cycle GREEN with active_way=winner, grant=1. Otherwise stay.
- **Pick rule:**
  - If preempt=1, the winner is preempt_way, even if not pending.
  - Otherwise the winner is the first pending way searching upward modulo 4 from active_way+1 (after reset, from way 0).
  - The winner becomes the new rr base.
- **GREEN:** others = pending with active_way bit masked. Go to YELLOW when any of the following holds:
  - preempt=1 and preempt_way!=active_way (immediate, ignores MIN_GREEN);
  - preempt=0 and others!=0 and cnt>=MIN_GREEN-1 and (req[active_way]=0 or cnt>=MAX_GREEN-1).
  - Otherwise hold green.
  - With no others pending, green holds indefinitely.
  - While preempt=1 with preempt_way==active_way, green holds.
- **YELLOW:** lasts exactly YELLOW cycles (exit at cnt==YELLOW-1) -> ALLRED. Not shortened by preempt.
- **ALLRED:** lasts exactly ALL_RED cycles. At exit apply the pick rule: winner -> GREEN (grant=1), none -> IDLE.
- **Lamp encoding:**
  - GREEN: g=onehot(active_way), y=0.
  - YELLOW: y=onehot(active_way), g=0.
  - IDLE/ALLRED: g=y=0.
  - Always r = ~(g|y).
  - Invariant: at most one approach is non-red; no way has more than one lamp lit.
- **Latency:** req high at edge t -> pending at t+1 -> green visible at t+2 from IDLE.
- **Reset mid-operation:** on the next edge, return to reset values (all red, pending cleared) regardless of state.

Decomposition:
- Package traffic_pkg: phase state enum (IDLE, GREEN, YELLOW, ALLRED), lamp ALL_RED_LAMPS=4'b1111, way index type (2 bits).
- Sub-module rr_arbiter4: combinational round-robin pick from a 4-bit pending mask and a 2-bit base. Outputs winner index and valid. Preempt override stays in the parent.

Test Plan:
- Reset, then req=4'b0001 for 1 cycle -> g=0001 two cycles later, grant pulses once, g stays 0001 for 30+ cycles with no other requests.
- Way0 green with req[0]=0; pulse req[2] -> green total 5 cycles, y=0001 for 3, r=1111 for 1, then g=0100.
- req[0] held high, req[1] pulsed at green entry -> green exactly 15 cycles, then yellow/all-red, g=0010.
- Way0 served last; pending=4'b1011 with no new reqs -> service order way1, way3, way0. Each gets 5 green + 3 yellow + 1 all-red.
- Way1 green at cnt=1; preempt=1, preempt_way=3 -> yellow next cycle (MIN ignored), all-red 1 cycle, g=1000, held while preempt=1, even with others pending.
- rst asserted mid-YELLOW -> next edge r=1111, g=y=0, pending=0; a new req[2] then yields g=0100 two cycles later.
